// File: rtl/sipo_rx_ctrl.sv
// Serial frame receiver: start bit, WIDTH data bits (LSB first), optional even
// parity, stop bit; good words go to a one-entry valid/ready holding register.
module sipo_rx_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             bit_en,
  output logic [WIDTH-1:0] po_data,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             par_err,
  output logic             frm_err,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             par_err_q, par_err_d;
  logic             frm_err_q, frm_err_d;
  logic             ovf_q, ovf_d;
  logic             good;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = valid_q;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovf_d     = 1'b0;
    good      = 1'b0;

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!si) begin
            state_d = SHIFT;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        SHIFT: begin
          shift_d = {si, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1))
            state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          par_d   = (^shift_q) ^ si;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit masks any parity problem in the same frame.
          if (!si)
            frm_err_d = 1'b1;
          else if (par_q)
            par_err_d = 1'b1;
          else
            good = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Holding register runs every cycle, independent of bit_en.
    if (good) begin
      if (!valid_q || po_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && po_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign po_data  = data_q;
  assign po_valid = valid_q;
  assign par_err  = par_err_q;
  assign frm_err  = frm_err_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl (WIDTH=4, PARITY_EN=1): frames, errors,
// overflow, bit_en gating and mid-frame reset.
module tb_sipo_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       si = 1'b1;
  logic       bit_en = 1'b0;
  logic [3:0] po_data;
  logic       po_valid;
  logic       po_ready = 1'b0;
  logic       par_err;
  logic       frm_err;
  logic       ovf;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sipo_rx_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .si       (si),
    .bit_en   (bit_en),
    .po_data  (po_data),
    .po_valid (po_valid),
    .po_ready (po_ready),
    .par_err  (par_err),
    .frm_err  (frm_err),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    si = b; bit_en = 1'b1;
    step();
    bit_en = 1'b0;
  endtask

  task automatic send_data(input logic [3:0] d, input logic p);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit(p);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    send_data(d, p);
    send_bit(stop);
  endtask

  task automatic drain();
    po_ready = 1'b1; si = 1'b1;
    step();
    po_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      si = i[0]; bit_en = 1'b1;
      step();
    end
    n_checks++;
    if ({po_data, po_valid, par_err, frm_err, ovf, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {po_data, po_valid, par_err, frm_err, ovf, busy});
    end
    si = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) step();
    bit_en = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b po_valid=%b required 0 0", busy, po_valid);
    end
    $display("test_reset: done");
  endtask

  task automatic test_good_frame();
    po_ready = 1'b0;
    send_bit(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    send_data(4'b1011, 1'b1);
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_before_stop: got %b required 0", po_valid);
    end
    send_bit(1'b1);
    $display("test_good_frame: frame data=1011 par=1 stop=1 -> po_data=%b po_valid=%b", po_data, po_valid);
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 4'b1011 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL good_frame: valid=%b data=%b busy=%b required 1 1011 0", po_valid, po_data, busy);
    end
    repeat (3) step();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 4'b1011) begin
      n_fail++;
      $display("FAIL hold_stable: valid=%b data=%b required 1 1011", po_valid, po_data);
    end
    drain();
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_clear: got %b required 0", po_valid);
    end
  endtask

  task automatic test_parity_err();
    send_frame(4'b1011, 1'b0, 1'b1);
    $display("test_parity_err: frame data=1011 par=0 -> par_err=%b po_valid=%b", par_err, po_valid);
    n_checks++;
    if (par_err !== 1'b1 || frm_err !== 1'b0 || po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_err: par_err=%b frm_err=%b valid=%b required 1 0 0", par_err, frm_err, po_valid);
    end
    step();
    n_checks++;
    if (par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_pulse_width: got %b required 0", par_err);
    end
  endtask

  task automatic test_frame_err();
    // Bad stop together with bad parity: only the framing error is reported.
    send_frame(4'b1011, 1'b0, 1'b0);
    $display("test_frame_err: frame data=1011 par=0 stop=0 -> frm_err=%b par_err=%b", frm_err, par_err);
    n_checks++;
    if (frm_err !== 1'b1 || par_err !== 1'b0 || po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frm_priority: frm_err=%b par_err=%b valid=%b required 1 0 0", frm_err, par_err, po_valid);
    end
    si = 1'b1; step();
    send_frame(4'b1011, 1'b1, 1'b0);
    n_checks++;
    if (frm_err !== 1'b1 || po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err: frm_err=%b valid=%b required 1 0", frm_err, po_valid);
    end
    // Line still low: next bit_en edge is a new start bit.
    send_bit(1'b0);
    n_checks++;
    if (busy !== 1'b1 || frm_err !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_after_frm: busy=%b frm_err=%b required 1 0", busy, frm_err);
    end
    send_data(4'b0101, 1'b0);
    send_bit(1'b1);
    $display("test_frame_err: restarted frame data=0101 -> po_data=%b po_valid=%b", po_data, po_valid);
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 4'b0101) begin
      n_fail++;
      $display("FAIL restart_word: valid=%b data=%b required 1 0101", po_valid, po_data);
    end
    drain();
  endtask

  task automatic test_overflow();
    po_ready = 1'b0;
    send_frame(4'b1011, 1'b1, 1'b1);
    send_frame(4'b0110, 1'b0, 1'b1);
    $display("test_overflow: second frame data=0110 -> ovf=%b po_data=%b", ovf, po_data);
    n_checks++;
    if (ovf !== 1'b1 || po_data !== 4'b1011 || po_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b data=%b valid=%b required 1 1011 1", ovf, po_data, po_valid);
    end
    step();
    n_checks++;
    if (ovf !== 1'b0 || po_data !== 4'b1011) begin
      n_fail++;
      $display("FAIL ovf_pulse_width: ovf=%b data=%b required 0 1011", ovf, po_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    po_ready = 1'b0;
    send_frame(4'b1011, 1'b1, 1'b1);
    send_bit(1'b0);
    send_data(4'b0110, 1'b0);
    po_ready = 1'b1;
    send_bit(1'b1);
    po_ready = 1'b0;
    $display("test_back_to_back: transfer+load on stop edge -> po_data=%b ovf=%b", po_data, ovf);
    n_checks++;
    if (ovf !== 1'b0 || po_data !== 4'b0110 || po_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: ovf=%b data=%b valid=%b required 0 0110 1", ovf, po_data, po_valid);
    end
    step();
    n_checks++;
    if (po_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_valid_held: got %b required 1", po_valid);
    end
    drain();
  endtask

  task automatic gated_bit(input logic b);
    si = b; bit_en = 1'b1;
    step();
    bit_en = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_bit_en_gating();
    int c0;
    logic [6:0] bits;
    bits = 7'b1110110;
    po_ready = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 6; i++) gated_bit(bits[i]);
    n_checks++;
    if (busy !== 1'b1 || po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gated_midframe: busy=%b valid=%b required 1 0", busy, po_valid);
    end
    gated_bit(bits[6]);
    $display("test_bit_en_gating: frame in %0d cycles -> po_data=%b", cyc - c0, po_data);
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 4'b1011 || (cyc - c0) != 21) begin
      n_fail++;
      $display("FAIL gated_frame: valid=%b data=%b cycles=%0d required 1 1011 21", po_valid, po_data, cyc - c0);
    end
    drain();
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gated_drain: got %b required 0", po_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b valid=%b required 0 0", busy, po_valid);
    end
    @(negedge clk); rst = 1'b0;
    si = 1'b1; step();
    send_frame(4'b1011, 1'b1, 1'b1);
    $display("test_reset_mid: clean frame after abort -> po_data=%b po_valid=%b", po_data, po_valid);
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 4'b1011) begin
      n_fail++;
      $display("FAIL post_reset_frame: valid=%b data=%b required 1 1011", po_valid, po_data);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_overflow();
    test_back_to_back();
    test_bit_en_gating();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
